// File: rtl/instr_sequencer.sv
// instr_sequencer: multi-cycle control FSM sequencing fetch, decode, execute, memory and write-back.
// Every control output is a combinational decode of the current state, ir, zero and mem_ready.
module instr_sequencer #(
   parameter logic [3:0] HALT_OP = 4'hF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] ir,
   input  logic        zero,
   input  logic        mem_ready,
   output logic        pc_ld,
   output logic        pc_incr,
   output logic        ir_ld,
   output logic        mem_rd,
   output logic        mem_wr,
   output logic        addr_sel,
   output logic        rf_we,
   output logic        wb_sel,
   output logic        halted,
   output logic [2:0]  state
);
   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4,
      HALT   = 3'd5
   } state_t;
   typedef struct packed {
      logic halted;
      logic wb_sel;
      logic rf_we;
      logic addr_sel;
      logic mem_wr;
      logic mem_rd;
      logic ir_ld;
      logic pc_incr;
      logic pc_ld;
   } ctl_t;
   state_t cur, nxt;
   ctl_t c;
   logic [3:0] op;
   logic is_halt, is_alu, is_ld, is_st, is_beq, is_jmp, unused_ir;
   assign op = ir[15:12];
   assign unused_ir = ^ir[11:0];
   assign is_halt = op == HALT_OP;
   assign is_alu = !is_halt && !op[3];
   assign is_ld = !is_halt && op == 4'h8;
   assign is_st = !is_halt && op == 4'h9;
   assign is_beq = !is_halt && op == 4'hA;
   assign is_jmp = !is_halt && op == 4'hB;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) cur <= FETCH;
      else cur <= nxt;
   end
   always_comb begin
      nxt = FETCH;
      c = '0;
      case (cur)
         FETCH: begin
            c.mem_rd = 1'b1;
            c.ir_ld = mem_ready;
            c.pc_incr = mem_ready;
            nxt = mem_ready ? DECODE : FETCH;
         end
         DECODE: nxt = is_halt ? HALT : EXEC;
         EXEC: begin
            c.pc_ld = is_jmp || (is_beq && zero);
            nxt = is_alu ? WB : (is_ld || is_st) ? MEM : FETCH;
         end
         MEM: begin
            c.addr_sel = 1'b1;
            c.mem_rd = is_ld;
            c.mem_wr = is_st;
            nxt = ((is_ld || is_st) && !mem_ready) ? MEM : is_ld ? WB : FETCH;
         end
         WB: begin
            c.rf_we = 1'b1;
            c.wb_sel = is_ld;
         end
         HALT: begin
            c.halted = 1'b1;
            nxt = HALT;
         end
         default: nxt = FETCH;
      endcase
   end
   // reset masks every output at once so an abandoned handshake drops in the same cycle
   assign pc_ld = c.pc_ld && !reset;
   assign pc_incr = c.pc_incr && !reset;
   assign ir_ld = c.ir_ld && !reset;
   assign mem_rd = c.mem_rd && !reset;
   assign mem_wr = c.mem_wr && !reset;
   assign addr_sel = c.addr_sel && !reset;
   assign rf_we = c.rf_we && !reset;
   assign wb_sel = c.wb_sel && !reset;
   assign halted = c.halted && !reset;
   assign state = cur;
endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: directed and randomized checks of instr_sequencer against a phase-list model.
module tb_instr_sequencer;
   logic clk = 1'b0, reset = 1'b1, zero = 1'b0, mem_ready = 1'b1;
   logic [15:0] ir = 16'h0;
   logic pc_ld, pc_incr, ir_ld, mem_rd, mem_wr, addr_sel, rf_we, wb_sel, halted;
   logic [2:0] state;
   logic [11:0] ov;
   int checks = 0, failures = 0;

   localparam int C_ALU = 0, C_LD = 1, C_ST = 2, C_BEQ = 3, C_JMP = 4, C_NOP = 5, C_HLT = 6;
   // phases visited by each instruction class, in order; -1 pads
   int seq [7][5] = '{'{0, 1, 2, 4, -1}, '{0, 1, 2, 3, 4}, '{0, 1, 2, 3, -1},
                      '{0, 1, 2, -1, -1}, '{0, 1, 2, -1, -1}, '{0, 1, 2, -1, -1},
                      '{0, 1, 5, -1, -1}};
   int len [7] = '{4, 5, 4, 3, 3, 3, 3};

   instr_sequencer dut (
      .clk(clk), .reset(reset), .ir(ir), .zero(zero), .mem_ready(mem_ready),
      .pc_ld(pc_ld), .pc_incr(pc_incr), .ir_ld(ir_ld), .mem_rd(mem_rd), .mem_wr(mem_wr),
      .addr_sel(addr_sel), .rf_we(rf_we), .wb_sel(wb_sel), .halted(halted), .state(state)
   );

   always #5 clk = ~clk;
   assign ov = {state, halted, wb_sel, rf_we, addr_sel, mem_wr, mem_rd, ir_ld, pc_incr, pc_ld};

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int cls_of(input logic [3:0] op);
      if (op == 4'hF) return C_HLT;
      if (op < 4'h8) return C_ALU;
      case (op)
         4'h8: return C_LD;
         4'h9: return C_ST;
         4'hA: return C_BEQ;
         4'hB: return C_JMP;
         default: return C_NOP;
      endcase
   endfunction

   function automatic logic [11:0] exp_out(input int ph, input int cls, input logic z, input logic mr);
      case (ph)
         0: return {3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, mr, mr, 1'b0};
         1: return 12'h200;
         2: return {3'd2, 8'b0, (cls == C_BEQ) ? z : (cls == C_JMP)};
         3: return {3'd3, 1'b0, 1'b0, 1'b0, 1'b1, cls == C_ST, cls == C_LD, 3'b0};
         4: return {3'd4, 1'b0, cls == C_LD, 1'b1, 6'b0};
         5: return 12'hB00;
         default: return 12'h000;
      endcase
   endfunction

   task automatic cyc(input string tag, input logic mr, input logic [11:0] e);
      mem_ready = mr;
      @(negedge clk);
      chk(tag, 16'(ov), 16'(e));
      @(posedge clk);
      #1;
   endtask

   task automatic do_rst();
      reset = 1'b1;
      @(negedge clk);
      chk("rst", 16'(ov), 16'h0);
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      int k, hc, cls, ph;
      logic rst_now;
      @(negedge clk);
      chk("rst_init", 16'(ov), 16'h0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      ir = 16'h1234;
      cyc("alu_f", 1, 12'h00E); cyc("alu_d", 1, 12'h200); cyc("alu_e", 1, 12'h400);
      cyc("alu_wb", 1, 12'h840); cyc("alu_next", 1, 12'h00E);
      do_rst();
      ir = 16'h8123;
      cyc("ld_fwait", 0, 12'h008); cyc("ld_f", 1, 12'h00E); cyc("ld_d", 1, 12'h200);
      cyc("ld_e", 1, 12'h400); cyc("ld_m0", 0, 12'h628); cyc("ld_m1", 0, 12'h628);
      cyc("ld_m2", 1, 12'h628); cyc("ld_wb", 1, 12'h8C0); cyc("ld_next", 1, 12'h00E);
      do_rst();
      ir = 16'h9abc;
      cyc("st_f", 1, 12'h00E); cyc("st_d", 1, 12'h200); cyc("st_e", 1, 12'h400);
      cyc("st_m", 1, 12'h630); cyc("st_next", 1, 12'h00E);
      do_rst();
      ir = 16'hA000;
      zero = 1'b0;
      cyc("beq0_f", 1, 12'h00E); cyc("beq0_d", 1, 12'h200); cyc("beq0_e", 1, 12'h400);
      zero = 1'b1;
      cyc("beq1_f", 1, 12'h00E); cyc("beq1_d", 1, 12'h200); cyc("beq1_e", 1, 12'h401);
      ir = 16'hB000;
      zero = 1'b0;
      cyc("jmp_f", 1, 12'h00E); cyc("jmp_d", 1, 12'h200); cyc("jmp_e", 1, 12'h401);
      ir = 16'hC000;
      cyc("nop_f", 1, 12'h00E); cyc("nop_d", 1, 12'h200); cyc("nop_e", 1, 12'h400);
      ir = 16'hF000;
      cyc("hlt_f", 1, 12'h00E); cyc("hlt_d", 1, 12'h200);
      for (int i = 0; i < 100; i++) begin
         zero = 1'($urandom);
         cyc("hlt_hold", 1'($urandom), 12'hB00);
      end
      do_rst();
      ir = 16'h1234;
      cyc("post_hlt_f", 1, 12'h00E);
      do_rst();
      ir = 16'h9000;
      cyc("ab_f", 1, 12'h00E); cyc("ab_d", 1, 12'h200); cyc("ab_e", 1, 12'h400);
      mem_ready = 1'b0;
      #1;
      chk("ab_mwait", 16'(ov), 16'h630);
      reset = 1'b1;
      #1;
      chk("ab_drop", 16'(ov), 16'h0);
      @(posedge clk);
      #1;
      chk("ab_hold", 16'(ov), 16'h0);
      reset = 1'b0;
      cyc("ab_fetch", 1, 12'h00E);
      do_rst();
      k = 0;
      hc = 0;
      for (int i = 0; i < 10000; i++) begin
         rst_now = (hc >= 8) || ($urandom_range(0, 299) == 0);
         if (k == 0) ir = 16'($urandom);
         zero = 1'($urandom);
         mem_ready = $urandom_range(0, 9) < 7;
         reset = rst_now;
         @(negedge clk);
         cls = cls_of(ir[15:12]);
         ph = seq[cls][k];
         chk("rnd", 16'(ov), rst_now ? 16'h0 : 16'(exp_out(ph, cls, zero, mem_ready)));
         chk("pc_excl", 16'(pc_ld & pc_incr), 16'h0);
         chk("mem_excl", 16'(mem_rd & mem_wr), 16'h0);
         chk("st_range", 16'(state <= 3'd5), 16'h1);
         if (rst_now) begin
            k = 0;
            hc = 0;
         end else if (ph == 5) hc++;
         else if (!((ph == 0 || ph == 3) && !mem_ready)) k = (k + 1 == len[cls]) ? 0 : k + 1;
         @(posedge clk);
         #1;
         reset = 1'b0;
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
